reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 Parameter NUM_OUTPUTS, default 4: number of sequenced reset outputs; legal range 1..16.
REQ-002 Parameter HOLD_CYCLES, default 16: clean cycles required before the first release; legal range 1..65535.
REQ-003 Parameter STAGGER_CYCLES, default 4: cycles between successive output releases; legal range 1..65535.
REQ-004 Parameter SYNC_STAGES, default 2: synchroniser depth for asynchronous inputs; legal range 2..4.
REQ-005 clk_i  input  1  the single clock; all logic is in this domain.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 ext_rst_i  input  1  external reset request; asynchronous, active-high, level.
REQ-008 pll_locked_i  input  1  clock-source lock indicator; asynchronous, active-high.
REQ-009 sw_rst_i  input  1  software reset request; synchronous to clk_i, single-cycle pulse.
REQ-010 rst_o  output  NUM_OUTPUTS  per-domain resets, active-high; bit 0 is released first.
REQ-011 ready_o  output  1  high when all rst_o bits are released.
REQ-012 state_o  output  2  current state encoding: 0=HOLD, 1=RELEASE, 2=RUN.
REQ-013 fault_cnt_o  output  8  saturating count of reset re-entries from RELEASE or RUN.

Function
REQ-014 ext_rst_i and pll_locked_i SHALL each pass through SYNC_STAGES flops: the ext chain resets to 1 and the lock chain resets to 0.
REQ-015 The fault term is fault = ext_sync | ~lock_sync | sw_rst_i.
REQ-016 The state machine SHALL have states HOLD, RELEASE and RUN, with a hold/stagger counter cnt and a release index idx.
REQ-017 In HOLD, all rst_o bits are 1 and ready_o is 0.
- cnt clears on any fault cycle and increments on each fault-free cycle.
REQ-018 HOLD to RELEASE: on the edge of a fault-free cycle with cnt == HOLD_CYCLES-1.
- rst_o[0] deasserts on that same edge.
- idx := 1; cnt := 0.
REQ-019 In RELEASE, cnt increments each fault-free cycle.
- When cnt == STAGGER_CYCLES-1: rst_o[idx] deasserts on that edge, idx increments and cnt := 0.
REQ-020 The edge that deasserts rst_o[NUM_OUTPUTS-1] SHALL also enter RUN and set ready_o.
- When NUM_OUTPUTS == 1, the HOLD exit edge enters RUN directly.
REQ-021 Released bits SHALL stay released, in ascending index order; no bit is ever released before a lower-indexed bit.
REQ-022 Any fault cycle in RELEASE or RUN SHALL, on the next edge:
- assert all rst_o bits and clear ready_o;
- enter HOLD with cnt := 0;
- increment fault_cnt_o, saturating at 255.
REQ-023 A fault in HOLD SHALL only clear cnt and SHALL NOT change fault_cnt_o.
REQ-024 Simultaneous fault and stagger expiry: the fault wins, so no further bit is released.
REQ-025 A sw_rst_i pulse in RUN SHALL cause exactly one full HOLD plus release sequence.
- Holding sw_rst_i high extends HOLD for as long as it stays high.
REQ-026 Counters SHALL be sized to hold max(HOLD_CYCLES, STAGGER_CYCLES) - 1; idx SHALL be sized to hold NUM_OUTPUTS.
REQ-027 rst_o and ready_o SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-028 While rst_i = 1:
- all rst_o = 1, ready_o = 0;
- state HOLD, cnt = 0, idx = 0;
- fault_cnt_o = 0;
- synchronisers at their reset values.
REQ-029 rst_i assertion SHALL force rst_o high asynchronously, without waiting for a clock edge, including mid-RELEASE and mid-RUN.
REQ-030 After rst_i deasserts with inputs clean, the first fault-free cycle SHALL occur no earlier than SYNC_STAGES edges later.
- This is because the lock synchroniser starts at 0.

Verification
REQ-031 Defaults; pll_locked_i=1 and ext_rst_i=0 throughout; rst_i released -> timing:
- rst_o[0] falls SYNC_STAGES+16 edges after release, allowing one edge of tolerance;
- rst_o[1], rst_o[2], rst_o[3] fall at +4, +8, +12 edges after rst_o[0];
- ready_o rises with rst_o[3]; state_o = 2.
REQ-032 RUN; 1-cycle sw_rst_i -> all rst_o = 1 and ready_o = 0 on the next edge.
- fault_cnt_o = 1; the full sequence repeats with identical timing.
REQ-033 pll_locked_i drops for 1 cycle mid-RELEASE, after rst_o[1] is released -> all bits reasserted.
- HOLD restarts; the release order is again 0..3.
REQ-034 ext_rst_i toggles every 10 cycles with HOLD_CYCLES=16 -> the block never leaves HOLD.
- rst_o stays all-ones; fault_cnt_o is unchanged.
REQ-035 rst_i pulsed asynchronously between edges during RUN -> rst_o all-ones before the next edge.
- fault_cnt_o = 0 afterwards.
REQ-036 NUM_OUTPUTS=1, HOLD_CYCLES=1, STAGGER_CYCLES=1; 300 forced faults -> fault_cnt_o saturates at 255.
- rst_o[0] and ready_o toggle together.

Source files
------------

// File: rtl/reset_seq.sv
// Reset sequencer: synchronises async reset sources, holds all domains in reset
// until the sources are clean, then releases the domain resets one at a time.
module reset_seq #(
  parameter int unsigned NUM_OUTPUTS    = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ext_rst_i,
  input  logic                   pll_locked_i,
  input  logic                   sw_rst_i,
  output logic [NUM_OUTPUTS-1:0] rst_o,
  output logic                   ready_o,
  output logic [1:0]             state_o,
  output logic [7:0]             fault_cnt_o
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IW      = $clog2(NUM_OUTPUTS + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] ext_ff;
  logic [SYNC_STAGES-1:0] lock_ff;
  logic                   fault;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0] rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [7:0]             fcnt_q, fcnt_d;

  // Ext chain starts asserted and lock chain starts unlocked, so nothing
  // releases until both have been sampled through the full chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ext_ff  <= '1;
      lock_ff <= '0;
    end else begin
      ext_ff  <= {ext_ff[SYNC_STAGES-2:0], ext_rst_i};
      lock_ff <= {lock_ff[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign fault = ext_ff[SYNC_STAGES-1] | ~lock_ff[SYNC_STAGES-1] | sw_rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    fcnt_d  = fcnt_q;

    unique case (state_q)
      HOLD: begin
        if (fault) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          rst_d[0] = 1'b0;
          idx_d    = IW'(1);
          cnt_d    = '0;
          if (NUM_OUTPUTS == 1) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RELEASE: begin
        // A fault takes priority over a coincident stagger expiry.
        if (!fault) begin
          if (cnt_q == STAG_LAST) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
              if (idx_q == IW'(i)) rst_d[i] = 1'b0;
            end
            idx_d = idx_q + IW'(1);
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      RUN: ;

      default: state_d = HOLD;
    endcase

    if (fault && (state_q == RELEASE || state_q == RUN)) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
    end
  end

  assign rst_o       = rst_q;
  assign ready_o     = ready_q;
  assign state_o     = state_q;
  assign fault_cnt_o = fcnt_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: default configuration plus a 1/1/1 instance
// for fault-counter saturation.
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       ext, pll, sw;
  logic [3:0] rst_o;
  logic       ready;
  logic [1:0] state;
  logic [7:0] fcnt;

  logic       ext1, pll1, sw1;
  logic [0:0] rst1;
  logic       ready1;
  logic [1:0] state1;
  logic [7:0] fcnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reset_seq dut (
    .clk_i(clk), .rst_i(rst), .ext_rst_i(ext), .pll_locked_i(pll), .sw_rst_i(sw),
    .rst_o(rst_o), .ready_o(ready), .state_o(state), .fault_cnt_o(fcnt)
  );

  reset_seq #(.NUM_OUTPUTS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .SYNC_STAGES(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .ext_rst_i(ext1), .pll_locked_i(pll1), .sw_rst_i(sw1),
    .rst_o(rst1), .ready_o(ready1), .state_o(state1), .fault_cnt_o(fcnt1)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until rst_o changes or the budget runs out; n = edges seen.
  task automatic wait_change(input int max, output int n);
    logic [3:0] prev;
    prev = rst_o;
    n = 0;
    do begin
      tick();
      n++;
    end while (rst_o == prev && n < max);
  endtask

  // Full release sequence: bit 0 after first_exp edges, then one bit every 4.
  task automatic seq_check(input string pfx, input int first_exp);
    int n;
    logic [3:0] pat;
    wait_change(200, n);
    check({pfx, "_t0"}, n, first_exp);
    check({pfx, "_p0"}, rst_o, 4'hE);
    check({pfx, "_st0"}, state, 1);
    for (int k = 1; k < 4; k++) begin
      wait_change(50, n);
      pat = 4'hF << (k + 1);
      check($sformatf("%s_t%0d", pfx, k), n, 4);
      check($sformatf("%s_p%0d", pfx, k), rst_o, pat);
      check($sformatf("%s_rdy%0d", pfx, k), ready, (k == 3) ? 1 : 0);
    end
    check({pfx, "_run"}, state, 2);
  endtask

  initial begin
    int n;
    int errs;
    int any_rel;

    rst = 1'b1; ext = 1'b0; pll = 1'b1; sw = 1'b0;
    ext1 = 1'b0; pll1 = 1'b1; sw1 = 1'b0;
    repeat (3) tick();
    check("rst_rsto", rst_o, 4'hF);
    check("rst_ready", ready, 0);
    check("rst_state", state, 0);
    check("rst_fcnt", fcnt, 0);
    check("rst_n1", rst1, 1);

    // Power-on release: 2 sync edges + 16 hold edges
    rst = 1'b0;
    seq_check("por", 18);

    // Software pulse in RUN
    sw = 1'b1;
    tick();
    sw = 1'b0;
    check("sw_rsto", rst_o, 4'hF);
    check("sw_ready", ready, 0);
    check("sw_state", state, 0);
    check("sw_fcnt", fcnt, 1);
    seq_check("sw", 16);

    // Lock glitch after rst_o[1] released
    sw = 1'b1;
    tick();
    sw = 1'b0;
    check("pre_fcnt", fcnt, 2);
    wait_change(100, n);
    check("pre_t0", n, 16);
    wait_change(50, n);
    check("pre_t1", n, 4);
    check("pre_p1", rst_o, 4'hC);
    pll = 1'b0;
    tick();
    pll = 1'b1;
    tick();
    check("pll_sync_lag", rst_o, 4'hC);
    tick();
    check("pll_rsto", rst_o, 4'hF);
    check("pll_state", state, 0);
    check("pll_ready", ready, 0);
    check("pll_fcnt", fcnt, 3);
    seq_check("pll", 16);

    // External reset toggling every 10 cycles keeps HOLD
    ext = 1'b1;
    repeat (10) tick();
    check("ext_rsto", rst_o, 4'hF);
    check("ext_fcnt", fcnt, 4);
    any_rel = 0;
    for (int p = 0; p < 8; p++) begin
      ext = ~ext;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (rst_o != 4'hF || state != 2'd0 || ready != 1'b0) any_rel++;
      end
    end
    check("ext_stuck_hold", any_rel, 0);
    check("ext_fcnt_hold", fcnt, 4);
    ext = 1'b0;
    seq_check("ext", 18);

    // Async reset pulse between edges in RUN
    #2 rst = 1'b1;
    #1;
    check("arst_rsto", rst_o, 4'hF);
    check("arst_ready", ready, 0);
    check("arst_state", state, 0);
    check("arst_fcnt", fcnt, 0);
    #1 rst = 1'b0;
    seq_check("arst", 18);

    // Single-output instance: 300 forced faults
    check("n1_run_rst", rst1, 0);
    check("n1_run_rdy", ready1, 1);
    check("n1_run_st", state1, 2);
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      sw1 = 1'b1;
      tick();
      if (rst1 != 1'b1 || ready1 != 1'b0 || state1 != 2'd0) errs++;
      sw1 = 1'b0;
      tick();
      if (rst1 != 1'b0 || ready1 != 1'b1 || state1 != 2'd2) errs++;
      if (i == 9) check("n1_cnt10", fcnt1, 10);
    end
    check("n1_toggle_errs", errs, 0);
    check("n1_sat", fcnt1, 255);
    check("n1_main_fcnt", fcnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
